// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: frame geometry, R/W encoding
// and the {CPOL, CPHA} mode encoding.
package spi_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall detect
// on the synchronised level (one extra history flop).
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_regbank.sv
// SPI peripheral register bank: write/read frames of {R/W, addr, data}, MSB
// first, fully oversampled in the clk domain; commits on chip-select release.
module spi_regbank
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int        FL    = frame_len(ADDR_W, DATA_W);
  localparam int        CNT_W = $clog2(FL + 1);
  localparam spi_mode_e MODE  = spi_mode_e'({CPOL[0], CPHA[0]});
  localparam logic      LEAD_IS_FALL    = mode_cpol(MODE);
  localparam logic      SAMPLE_ON_TRAIL = mode_cpha(MODE);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_level;
  logic w_ncs, w_ncs_rise, w_ncs_fall;
  logic w_copi, w_unused_copi_rise, w_unused_copi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(sclk),
    .o_level(w_unused_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(ncs),
    .o_level(w_ncs), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(copi),
    .o_level(w_copi), .o_rise(w_unused_copi_rise), .o_fall(w_unused_copi_fall));

  logic w_lead, w_trail, w_sample, w_drive;
  assign w_lead   = LEAD_IS_FALL ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = LEAD_IS_FALL ? w_sclk_rise : w_sclk_fall;
  assign w_sample = SAMPLE_ON_TRAIL ? w_trail : w_lead;
  assign w_drive  = SAMPLE_ON_TRAIL ? w_lead : w_trail;

  logic [CNT_W-1:0]  r_cnt;
  logic [FL-1:0]     r_shift;
  logic [DATA_W-1:0] r_shadow;
  logic              r_rd_act;
  logic              r_cipo;
  logic              r_cipo_oe;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_err;

  logic [FL-1:0]     w_shift_nxt;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic              w_hdr_rw;
  logic [DATA_W-1:0] w_rd_val;
  logic [ADDR_W-1:0] w_cmt_addr;
  logic              w_full;

  // Header fields as they will look once the current bit is shifted in.
  always_comb begin
    w_shift_nxt = {r_shift[FL-2:0], w_copi};
    w_hdr_addr  = w_shift_nxt[ADDR_W-1:0];
    w_hdr_rw    = w_shift_nxt[ADDR_W];
    w_cmt_addr  = r_shift[DATA_W +: ADDR_W];
    w_full      = (r_cnt == CNT_W'(FL));
    w_rd_val    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_hdr_addr == ADDR_W'(i)) w_rd_val = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_shadow    <= '0;
      r_rd_act    <= 1'b0;
      r_cipo      <= 1'b0;
      r_cipo_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_cipo_oe   <= ~w_ncs;
      if (w_ncs_fall) begin
        r_cnt    <= '0;
        r_shift  <= '0;
        r_shadow <= '0;
        r_rd_act <= 1'b0;
        r_cipo   <= 1'b0;
      end else if (w_ncs_rise) begin
        r_rd_act <= 1'b0;
        r_cipo   <= 1'b0;
        if (w_full) begin
          if (r_shift[FL-1] == RW_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_cmt_addr == ADDR_W'(i)) begin
                r_regs[i]   <= r_shift[DATA_W-1:0];
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= w_cmt_addr;
              end
            end
          end
        end else if (r_cnt != '0) begin
          r_frame_err <= 1'b1;
        end
      end else if (!w_ncs) begin
        if (w_sample && !w_full) begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ADDR_W) && w_hdr_rw == RW_READ) begin
            r_shadow <= w_rd_val;
            r_rd_act <= 1'b1;
          end
        end
        if (w_drive && r_rd_act) begin
          r_cipo   <= r_shadow[DATA_W-1];
          r_shadow <= {r_shadow[DATA_W-2:0], 1'b0};
        end
      end else begin
        r_cipo <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign cipo      = r_cipo;
  assign cipo_oe   = r_cipo_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regbank.sv
// Bench for spi_regbank: a mode-0 instance and a CPOL=1/CPHA=1 instance share
// ncs/copi; each has its own sclk. Commits are checked through a scoreboard.
module tb_spi_regbank;

  localparam time HALF = 80ns;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ncs = 1'b1;
  logic        copi = 1'b0;
  logic        sclk_a = 1'b0;
  logic        sclk_b = 1'b1;
  logic        cipo_a, cipo_oe_a, wr_strobe_a, frame_err_a;
  logic        cipo_b, cipo_oe_b, wr_strobe_b, frame_err_b;
  logic [39:0] regs_out_a, regs_out_b;
  logic [6:0]  wr_addr_a, wr_addr_b;

  spi_regbank u_dut_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .ncs(ncs), .copi(copi),
    .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_out(regs_out_a),
    .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a));

  spi_regbank #(.CPOL(1), .CPHA(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .ncs(ncs), .copi(copi),
    .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_out(regs_out_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b));

  always #5ns clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_str_a = 0, n_err_a = 0, n_str_b = 0, n_err_b = 0;
  logic [14:0] sb_a[$];
  logic [14:0] sb_b[$];
  logic [7:0]  m_a[5];
  logic [7:0]  m_b[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] flat(input logic [7:0] m[5]);
    logic [39:0] f;
    for (int i = 0; i < 5; i++) f[i*8 +: 8] = m[i];
    return f;
  endfunction

  // Commit monitors: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    logic [14:0] e;
    int idx;
    if (wr_strobe_a === 1'b1) begin
      n_str_a++;
      chk("sb_a_pending", 64'(sb_a.size() != 0), 64'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        idx = int'(e[14:8]);
        chk("wr_addr_a", 64'(wr_addr_a), 64'(e[14:8]));
        chk("wr_data_a", 64'(regs_out_a[idx*8 +: 8]), 64'(e[7:0]));
      end
    end
    if (frame_err_a === 1'b1) n_err_a++;
  end

  always @(negedge clk) begin
    logic [14:0] e;
    int idx;
    if (wr_strobe_b === 1'b1) begin
      n_str_b++;
      chk("sb_b_pending", 64'(sb_b.size() != 0), 64'd1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        idx = int'(e[14:8]);
        chk("wr_addr_b", 64'(wr_addr_b), 64'(e[14:8]));
        chk("wr_data_b", 64'(regs_out_b[idx*8 +: 8]), 64'(e[7:0]));
      end
    end
    if (frame_err_b === 1'b1) n_err_b++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input bit m3, input logic [15:0] frame, input int nbits,
                      input bit raise, output logic [7:0] rd);
    rd = '0;
    @(negedge clk);
    ncs = 1'b0;
    #HALF;
    for (int b = 0; b < nbits; b++) begin
      if (m3) sclk_b = 1'b0;
      copi = frame[15-b];
      #HALF;
      if (b >= 8) rd = {rd[6:0], (m3 ? cipo_b : cipo_a)};
      if (m3) sclk_b = 1'b1;
      else    sclk_a = 1'b1;
      #HALF;
      if (!m3) sclk_a = 1'b0;
    end
    copi = 1'b0;
    if (raise) begin
      #HALF;
      ncs = 1'b1;
      repeat (12) @(negedge clk);
    end
  endtask

  typedef struct {
    bit          m3;
    logic [15:0] frame;
    int          nbits;
    int          exp_str;
    int          exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    vec_t v;
    logic [7:0] rd;
    int s_a, e_a, s_b, e_b, idx, lat;

    vecs[0]  = '{1'b0, 16'h84A5, 16, 1, 0, 8'h00};
    vecs[1]  = '{1'b0, 16'h813C, 16, 1, 0, 8'h00};
    vecs[2]  = '{1'b0, 16'h0100, 16, 0, 0, 8'h3C};
    vecs[3]  = '{1'b0, 16'h8A55, 16, 0, 0, 8'h00};
    vecs[4]  = '{1'b0, 16'h0A00, 16, 0, 0, 8'h00};
    vecs[5]  = '{1'b0, 16'h83FF,  9, 0, 1, 8'h00};
    vecs[6]  = '{1'b0, 16'h83FF, 16, 1, 0, 8'h00};
    vecs[7]  = '{1'b1, 16'h82C3, 16, 1, 0, 8'h00};
    vecs[8]  = '{1'b1, 16'h0200, 16, 0, 0, 8'hC3};
    vecs[9]  = '{1'b0, 16'h0400, 16, 0, 0, 8'hA5};
    vecs[10] = '{1'b0, 16'h0000,  0, 0, 0, 8'h00};
    vecs[11] = '{1'b1, 16'h8207,  5, 0, 1, 8'h00};
    for (int i = 0; i < 5; i++) begin m_a[i] = '0; m_b[i] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_regs_a", 64'(regs_out_a), 64'd0);
    chk("rst_regs_b", 64'(regs_out_b), 64'd0);
    chk("rst_outs_a", 64'({wr_strobe_a, wr_addr_a, frame_err_a, cipo_a, cipo_oe_a}), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_err", 64'(n_err_a + n_err_b + n_str_a + n_str_b), 64'd0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      s_a = n_str_a; e_a = n_err_a; s_b = n_str_b; e_b = n_err_b;
      if (v.nbits == 16 && v.frame[15] && v.frame[14:8] < 7'd5) begin
        idx = int'(v.frame[14:8]);
        if (v.m3) begin m_b[idx] = v.frame[7:0]; sb_b.push_back(v.frame[14:0]); end
        else      begin m_a[idx] = v.frame[7:0]; sb_a.push_back(v.frame[14:0]); end
      end
      xfer(v.m3, v.frame, v.nbits, 1'b1, rd);
      if (v.m3) begin
        chk($sformatf("v%0d_strobe", i), 64'(n_str_b - s_b), 64'(v.exp_str));
        chk($sformatf("v%0d_ferr", i),   64'(n_err_b - e_b), 64'(v.exp_err));
        chk($sformatf("v%0d_other", i),  64'(n_str_a - s_a + n_err_a - e_a), 64'd0);
      end else begin
        chk($sformatf("v%0d_strobe", i), 64'(n_str_a - s_a), 64'(v.exp_str));
        chk($sformatf("v%0d_ferr", i),   64'(n_err_a - e_a), 64'(v.exp_err));
        chk($sformatf("v%0d_other", i),  64'(n_str_b - s_b + n_err_b - e_b), 64'd0);
      end
      if (v.nbits == 16) chk($sformatf("v%0d_cipo", i), 64'(rd), 64'(v.exp_rd));
      chk($sformatf("v%0d_regs_a", i), 64'(regs_out_a), 64'(flat(m_a)));
      chk($sformatf("v%0d_regs_b", i), 64'(regs_out_b), 64'(flat(m_b)));
    end

    // Latency from ncs pin rise to register update
    m_a[0] = 8'h5A;
    sb_a.push_back(15'h005A);
    xfer(1'b0, 16'h805A, 16, 1'b0, rd);
    #HALF;
    chk("oe_mid_frame", 64'(cipo_oe_a), 64'd1);
    @(negedge clk);
    ncs = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (regs_out_a[7:0] == 8'h5A) begin lat = k; break; end
    end
    chk("commit_latency", 64'(lat), 64'd3);
    repeat (10) @(negedge clk);
    chk("lat_regs_a", 64'(regs_out_a), 64'(flat(m_a)));
    chk("oe_idle", 64'(cipo_oe_a), 64'd0);

    // Reset in the middle of a write frame
    xfer(1'b0, 16'h8011, 12, 1'b0, rd);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin m_a[i] = '0; m_b[i] = '0; end
    chk("midrst_regs_a", 64'(regs_out_a), 64'd0);
    chk("midrst_outs_a", 64'({wr_strobe_a, wr_addr_a, frame_err_a, cipo_a, cipo_oe_a}), 64'd0);
    chk("midrst_regs_b", 64'(regs_out_b), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    s_a = n_str_a; e_a = n_err_a;
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_strobe", 64'(n_str_a - s_a), 64'd0);
    chk("midrst_no_ferr", 64'(n_err_a - e_a), 64'd0);
    chk("midrst_reg0", 64'(regs_out_a), 64'(flat(m_a)));
    chk("sb_a_drained", 64'(sb_a.size()), 64'd0);
    chk("sb_b_drained", 64'(sb_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
